// File: rtl/osiris_pkg.sv
// Shared definitions for the osiris data-memory stage: load/store size codes,
// datapath width and the loader handshake state encoding.
package osiris_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    LDR_IDLE = 1'b0,
    LDR_ACK  = 1'b1
  } ldr_state_e;

  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/osiris_lsu_align.sv
// Combinational lane steering: store byte-enables and replicated store data,
// load extraction with sign/zero extension, and alignment checks.
module osiris_lsu_align
  import osiris_pkg::*;
(
  input  logic [2:0]            i_funct3,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  input  logic [DATA_WIDTH-1:0] i_mem_word,
  output logic [3:0]            o_store_be,
  output logic [DATA_WIDTH-1:0] o_store_data,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_misaligned,
  output logic                  o_illegal_store,
  output logic                  o_load_code
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte         = i_mem_word[{i_addr_lo, 3'b000} +: 8];
  assign ld_half         = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
  assign o_illegal_store = !is_store_f3(i_funct3);
  assign o_load_code     = is_load_f3(i_funct3);

  always_comb begin
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: o_misaligned = i_addr_lo[0];
      F3_W:        o_misaligned = (i_addr_lo != 2'b00);
      default:     o_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   o_load_data = {24'h0, ld_byte};
      F3_H:    o_load_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   o_load_data = {16'h0, ld_half};
      F3_W:    o_load_data = i_mem_word;
      default: o_load_data = '0;
    endcase
    if (o_misaligned) o_load_data = '0;
  end

  // Data is replicated across lanes so the byte-enables alone pick the target.
  always_comb begin
    o_store_be   = 4'b0000;
    o_store_data = '0;
    case (i_funct3)
      F3_B: begin
        o_store_be   = 4'b0001 << i_addr_lo;
        o_store_data = {4{i_store_data[7:0]}};
      end
      F3_H: begin
        o_store_be   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_store_data = {2{i_store_data[15:0]}};
      end
      F3_W: begin
        o_store_be   = 4'b1111;
        o_store_data = i_store_data;
      end
      default: begin
        o_store_be   = 4'b0000;
        o_store_data = '0;
      end
    endcase
    if (o_misaligned) o_store_be = 4'b0000;
  end

endmodule

// File: rtl/osiris_dmem_lsu.sv
// Data memory for the core's M stage with a single-outstanding loader port.
// Core loads are combinational; all writes land on the rising clock edge.
module osiris_dmem_lsu
  import osiris_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_MEM,
  input  logic [31:0]           i_data_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  input  logic                  i_ext_en,
  input  logic                  i_ext_stb,
  input  logic                  i_ext_we,
  input  logic [31:0]           i_ext_addr,
  input  logic [3:0]            i_ext_sel,
  input  logic [DATA_WIDTH-1:0] i_ext_wdata,
  output logic                  o_ext_ack,
  output logic [DATA_WIDTH-1:0] o_ext_rdata,
  input  logic                  i_err_clr,
  output logic                  o_misaligned,
  output logic [7:0]            o_misaligned_cnt
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic [ADDR_W-1:0]     core_idx;
  logic [ADDR_W-1:0]     ext_idx;
  logic [DATA_WIDTH-1:0] core_word;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_data;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  misaligned;
  logic                  illegal_store;
  logic                  load_code;

  ldr_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] ext_rdata_q, ext_rdata_d;
  logic                  err_flag_q, err_flag_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  err_event;

  logic [3:0]            wr_be;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_W-1:0]     wr_idx;

  // Upper address bits are deliberately ignored: the array aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_data_addr_M[31:ADDR_W+2], i_ext_addr[31:ADDR_W+2],
                              i_ext_addr[1:0]};

  assign core_idx  = i_data_addr_M[ADDR_W+1:2];
  assign ext_idx   = i_ext_addr[ADDR_W+1:2];
  assign core_word = mem_q[core_idx];

  osiris_lsu_align u_align (
    .i_funct3        (i_funct3_MEM),
    .i_addr_lo       (i_data_addr_M[1:0]),
    .i_store_data    (i_write_data_M),
    .i_mem_word      (core_word),
    .o_store_be      (st_be),
    .o_store_data    (st_data),
    .o_load_data     (ld_data),
    .o_misaligned    (misaligned),
    .o_illegal_store (illegal_store),
    .o_load_code     (load_code)
  );

  assign o_read_data_M    = i_ext_en ? '0 : ld_data;
  assign o_ext_ack        = (state_q == LDR_ACK);
  assign o_ext_rdata      = ext_rdata_q;
  assign o_misaligned     = err_flag_q;
  assign o_misaligned_cnt = err_cnt_q;

  // Loader handshake: valid = i_ext_en & i_ext_stb sampled in IDLE; the access
  // completes on that edge and o_ext_ack is high for exactly the following cycle.
  always_comb begin
    state_d     = state_q;
    ext_rdata_d = ext_rdata_q;
    wr_be       = 4'b0000;
    wr_data     = '0;
    wr_idx      = core_idx;
    case (state_q)
      LDR_IDLE: begin
        if (i_ext_en && i_ext_stb) begin
          state_d = LDR_ACK;
          if (i_ext_we) begin
            wr_be   = i_ext_sel;
            wr_data = i_ext_wdata;
            wr_idx  = ext_idx;
          end else begin
            ext_rdata_d = mem_q[ext_idx];
          end
        end
      end
      LDR_ACK:  state_d = LDR_IDLE;
      default:  state_d = LDR_IDLE;
    endcase
    if (!i_ext_en && i_mem_write_M) begin
      wr_be   = illegal_store ? 4'b0000 : st_be;
      wr_data = st_data;
      wr_idx  = core_idx;
    end
  end

  always_comb begin
    err_event = 1'b0;
    if (!i_ext_en) begin
      if (i_mem_write_M) err_event = misaligned || illegal_store;
      else               err_event = load_code && misaligned;
    end
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    if (i_err_clr) begin
      err_flag_d = 1'b0;
      err_cnt_d  = 8'd0;
    end else if (err_event) begin
      err_flag_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LDR_IDLE;
      ext_rdata_q <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      ext_rdata_q <= ext_rdata_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Array contents survive reset; reset only blocks a write in its cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_be[l]) mem_q[wr_idx][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

endmodule

// File: tb/tb_osiris_dmem_lsu.sv
// Directed bench for osiris_dmem_lsu with hand-computed expected values.
module tb_osiris_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_mem_write_M;
  logic [2:0]  i_funct3_MEM;
  logic [31:0] i_data_addr_M;
  logic [31:0] i_write_data_M;
  logic [31:0] o_read_data_M;
  logic        i_ext_en;
  logic        i_ext_stb;
  logic        i_ext_we;
  logic [31:0] i_ext_addr;
  logic [3:0]  i_ext_sel;
  logic [31:0] i_ext_wdata;
  logic        o_ext_ack;
  logic [31:0] o_ext_rdata;
  logic        i_err_clr;
  logic        o_misaligned;
  logic [7:0]  o_misaligned_cnt;

  int n_cmp = 0;
  int n_err = 0;

  osiris_dmem_lsu dut (
    .clk              (clk),
    .rst              (rst),
    .i_mem_write_M    (i_mem_write_M),
    .i_funct3_MEM     (i_funct3_MEM),
    .i_data_addr_M    (i_data_addr_M),
    .i_write_data_M   (i_write_data_M),
    .o_read_data_M    (o_read_data_M),
    .i_ext_en         (i_ext_en),
    .i_ext_stb        (i_ext_stb),
    .i_ext_we         (i_ext_we),
    .i_ext_addr       (i_ext_addr),
    .i_ext_sel        (i_ext_sel),
    .i_ext_wdata      (i_ext_wdata),
    .o_ext_ack        (o_ext_ack),
    .o_ext_rdata      (o_ext_rdata),
    .i_err_clr        (i_err_clr),
    .o_misaligned     (o_misaligned),
    .o_misaligned_cnt (o_misaligned_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic flag, input logic [7:0] cnt);
    check({tag, "_flag"}, {31'b0, o_misaligned}, {31'b0, flag});
    check({tag, "_cnt"}, {24'b0, o_misaligned_cnt}, {24'b0, cnt});
  endtask

  task automatic ext_write(input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    i_ext_stb = 1'b1; i_ext_we = 1'b1;
    i_ext_addr = addr; i_ext_sel = sel; i_ext_wdata = data;
    #1 check("ext_wr_ack_pre", {31'b0, o_ext_ack}, 32'd0);
    step();
    check("ext_wr_ack", {31'b0, o_ext_ack}, 32'd1);
    i_ext_stb = 1'b0; i_ext_we = 1'b0;
    step();
    check("ext_wr_ack_drop", {31'b0, o_ext_ack}, 32'd0);
  endtask

  task automatic ext_read(input logic [31:0] addr, input logic [31:0] exp);
    i_ext_stb = 1'b1; i_ext_we = 1'b0; i_ext_addr = addr;
    #1 check("ext_rd_ack_pre", {31'b0, o_ext_ack}, 32'd0);
    step();
    check("ext_rd_ack", {31'b0, o_ext_ack}, 32'd1);
    check("ext_rd_data", o_ext_rdata, exp);
    i_ext_stb = 1'b0;
    step();
    check("ext_rd_ack_drop", {31'b0, o_ext_ack}, 32'd0);
  endtask

  task automatic core_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
    i_mem_write_M = 1'b0; i_funct3_MEM = f3; i_data_addr_M = addr;
    #1 check(tag, o_read_data_M, exp);
  endtask

  task automatic core_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    i_mem_write_M = 1'b1; i_funct3_MEM = f3; i_data_addr_M = addr; i_write_data_M = data;
    step();
    i_mem_write_M = 1'b0; i_funct3_MEM = 3'b011;
  endtask

  initial begin
    rst = 1'b1;
    i_mem_write_M = 1'b0; i_funct3_MEM = 3'b011; i_data_addr_M = '0; i_write_data_M = '0;
    i_ext_en = 1'b0; i_ext_stb = 1'b0; i_ext_we = 1'b0;
    i_ext_addr = '0; i_ext_sel = 4'h0; i_ext_wdata = '0; i_err_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_ack", {31'b0, o_ext_ack}, 32'd0);
    check("rst_rdata", o_ext_rdata, 32'd0);
    check_err("rst", 1'b0, 8'd0);

    // Loader preload and read-back.
    i_ext_en = 1'b1;
    ext_write(32'h10, 4'hF, 32'h8000_00F1);
    ext_read(32'h10, 32'h8000_00F1);
    ext_write(32'h20, 4'hF, 32'h0);
    ext_write(32'h30, 4'hF, 32'hCAFE_F00D);
    ext_write(32'h14, 4'hF, 32'h0);
    ext_write(32'h14, 4'b0101, 32'h1122_3344);
    ext_read(32'h17, 32'h0022_0044);
    ext_write(32'h40, 4'hF, 32'h55AA_55AA);

    // Back-to-back reads with stb held high: ack, idle, ack.
    i_ext_stb = 1'b1; i_ext_we = 1'b0; i_ext_addr = 32'h10;
    step();
    check("b2b_ack1", {31'b0, o_ext_ack}, 32'd1);
    step();
    check("b2b_gap", {31'b0, o_ext_ack}, 32'd0);
    i_ext_addr = 32'h30;
    step();
    check("b2b_ack2", {31'b0, o_ext_ack}, 32'd1);
    check("b2b_rdata", o_ext_rdata, 32'hCAFE_F00D);
    i_ext_stb = 1'b0;
    step();

    core_load("load_blocked_by_ext_en", 3'b010, 32'h10, 32'h0);

    // Core loads.
    i_ext_en = 1'b0;
    core_load("lb_10",   3'b000, 32'h10,  32'hFFFF_FFF1);
    core_load("lbu_13",  3'b100, 32'h13,  32'h0000_0080);
    core_load("lb_13",   3'b000, 32'h13,  32'hFFFF_FF80);
    core_load("lh_12",   3'b001, 32'h12,  32'hFFFF_8000);
    core_load("lhu_12",  3'b101, 32'h12,  32'h0000_8000);
    core_load("lw_10",   3'b010, 32'h10,  32'h8000_00F1);
    core_load("lw_alias",3'b010, 32'h410, 32'h8000_00F1);
    core_load("f3_011",  3'b011, 32'h10,  32'h0);
    step();
    check_err("after_loads", 1'b0, 8'd0);

    // Core byte and halfword stores.
    core_store(3'b000, 32'h21, 32'hFFFF_FFAB);
    core_load("sb_result", 3'b010, 32'h20, 32'h0000_AB00);
    core_store(3'b001, 32'h22, 32'hFFFF_1234);
    core_load("sh_result", 3'b010, 32'h20, 32'h1234_AB00);
    check_err("after_stores", 1'b0, 8'd0);

    // Misaligned store and load.
    core_store(3'b010, 32'h31, 32'h1111_1111);
    check_err("mis_sw", 1'b1, 8'd1);
    core_load("mis_lh_data", 3'b001, 32'h23, 32'h0);
    step();
    check_err("mis_lh", 1'b1, 8'd2);
    core_load("mis_sw_no_write", 3'b010, 32'h30, 32'hCAFE_F00D);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    check_err("err_clr", 1'b0, 8'd0);

    // Illegal store size is counted and suppressed.
    core_store(3'b011, 32'h30, 32'h0);
    check_err("illegal_store", 1'b1, 8'd1);
    core_load("illegal_no_write", 3'b010, 32'h30, 32'hCAFE_F00D);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;

    // Saturation after 300 misaligned stores, then clear beats a new error.
    i_mem_write_M = 1'b1; i_funct3_MEM = 3'b010; i_data_addr_M = 32'h31; i_write_data_M = 32'h0;
    for (int k = 0; k < 300; k++) step();
    check_err("saturate", 1'b1, 8'd255);
    i_err_clr = 1'b1;
    step();
    check_err("clr_wins", 1'b0, 8'd0);
    i_err_clr = 1'b0; i_mem_write_M = 1'b0; i_funct3_MEM = 3'b011;
    core_load("sat_no_write", 3'b010, 32'h30, 32'hCAFE_F00D);

    // Reset with a loader write strobe pending.
    i_ext_en = 1'b1; i_ext_stb = 1'b1; i_ext_we = 1'b1;
    i_ext_addr = 32'h40; i_ext_sel = 4'hF; i_ext_wdata = 32'hDEAD_BEEF;
    rst = 1'b1;
    step();
    check("rst_stb_ack", {31'b0, o_ext_ack}, 32'd0);
    check("rst_stb_rdata", o_ext_rdata, 32'd0);
    check_err("rst_stb", 1'b0, 8'd0);
    i_ext_stb = 1'b0; i_ext_we = 1'b0; rst = 1'b0;
    step();
    check("rst_stb_no_ack", {31'b0, o_ext_ack}, 32'd0);
    ext_read(32'h40, 32'h55AA_55AA);

    // Reset during ACK drops ack next cycle.
    i_ext_stb = 1'b1; i_ext_we = 1'b0; i_ext_addr = 32'h40;
    step();
    check("ack_before_rst", {31'b0, o_ext_ack}, 32'd1);
    i_ext_stb = 1'b0; rst = 1'b1;
    step();
    check("ack_after_rst", {31'b0, o_ext_ack}, 32'd0);
    rst = 1'b0;

    // Core store while the loader owns memory is ignored, errors too.
    i_mem_write_M = 1'b1; i_funct3_MEM = 3'b010; i_data_addr_M = 32'h40; i_write_data_M = 32'h0;
    #1 check("ext_en_read_zero", o_read_data_M, 32'h0);
    step();
    i_data_addr_M = 32'h41;
    step();
    i_mem_write_M = 1'b0; i_ext_en = 1'b0;
    core_load("ext_en_sw_ignored", 3'b010, 32'h40, 32'h55AA_55AA);
    check_err("ext_en_no_err", 1'b0, 8'd0);

    // Strobe without ownership never acks.
    i_ext_stb = 1'b1; i_ext_we = 1'b1; i_ext_addr = 32'h40; i_ext_wdata = 32'h0;
    step();
    check("stb_no_en_1", {31'b0, o_ext_ack}, 32'd0);
    step();
    check("stb_no_en_2", {31'b0, o_ext_ack}, 32'd0);
    i_ext_stb = 1'b0; i_ext_we = 1'b0;
    core_load("stb_no_en_no_write", 3'b010, 32'h40, 32'h55AA_55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
